// File: rtl/bist_pkg.sv
// Shared types for the BIST response checker: session FSM states and default MISR taps.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPARE = 2'd2
  } state_t;

  // Primitive feedback taps for the supported signature widths; 8-bit taps otherwise.
  function automatic logic [31:0] default_poly(input int sig_w);
    case (sig_w)
      3:       return 32'h0000_0003;
      16:      return 32'h0000_100B;
      default: return 32'h0000_001D;
    endcase
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Single-channel MISR: one-cycle update when en is high, clr wins over en; no backpressure.
module bist_misr
  import bist_pkg::*;
#(
  parameter int                 SIG_W = 8,
  parameter logic [SIG_W-1:0]   POLY  = SIG_W'(default_poly(SIG_W))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] d,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] r_q;
  logic [SIG_W-1:0] w_fb;
  logic [SIG_W-1:0] w_nxt;

  // Shift out the MSB and fold it back through the taps before mixing in the response.
  assign w_fb  = r_q[SIG_W-1] ? POLY : '0;
  assign w_nxt = {r_q[SIG_W-2:0], 1'b0} ^ w_fb ^ d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bist_misr_checker.sv
// Session-based BIST response analyser: NCH MISRs, done registered one edge after the last vector.
// Gaps in resp_valid simply stretch the session; abort overrides everything and suppresses done.
module bist_misr_checker
  import bist_pkg::*;
#(
  parameter int               SIG_W = 8,
  parameter int               NCH   = 4,
  parameter int               CNT_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(default_poly(SIG_W))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     test_len,
  input  logic [NCH*SIG_W-1:0] golden_sig,
  input  logic                 resp_valid,
  input  logic [NCH*SIG_W-1:0] resp,
  output logic                 busy,
  output logic                 done,
  output logic                 result,
  output logic [NCH-1:0]       fail_mask,
  output logic [NCH*SIG_W-1:0] signature
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_len;
  logic [NCH*SIG_W-1:0] r_golden;
  logic                 r_done;
  logic                 r_result;
  logic [NCH-1:0]       r_fail_mask;

  logic                 w_misr_clr;
  logic                 w_misr_en;
  logic                 w_accept;
  logic                 w_cmp;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_last;
  logic [NCH-1:0]       w_mismatch;
  logic [NCH*SIG_W-1:0] w_sig;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_misr_clr  = 1'b0;
    w_misr_en   = 1'b0;
    w_accept    = 1'b0;
    w_cmp       = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_misr_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_accept    = 1'b1;
            w_misr_clr  = 1'b1;
            w_state_nxt = (test_len == '0) ? ST_COMPARE : ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (resp_valid) begin
            w_misr_en = 1'b1;
            if (w_last) begin
              w_state_nxt = ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          w_cmp       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_golden    <= '0;
      r_done      <= 1'b0;
      r_result    <= 1'b0;
      r_fail_mask <= '0;
    end else begin
      r_done <= w_cmp;
      if (abort) begin
        r_cnt       <= '0;
        r_result    <= 1'b0;
        r_fail_mask <= '0;
      end else begin
        if (w_accept) begin
          r_len       <= test_len;
          r_golden    <= golden_sig;
          r_cnt       <= '0;
          r_result    <= 1'b0;
          r_fail_mask <= '0;
        end
        if (w_misr_en) begin
          r_cnt <= w_cnt_inc;
        end
        if (w_cmp) begin
          r_fail_mask <= w_mismatch;
          r_result    <= |w_mismatch;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    bist_misr #(
      .SIG_W (SIG_W),
      .POLY  (POLY)
    ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_misr_clr),
      .en    (w_misr_en),
      .d     (resp[c*SIG_W +: SIG_W]),
      .q     (w_sig[c*SIG_W +: SIG_W])
    );
    assign w_mismatch[c] = (w_sig[c*SIG_W +: SIG_W] != r_golden[c*SIG_W +: SIG_W]);
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign fail_mask = r_fail_mask;
  assign signature = w_sig;

endmodule
